// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchronizer, debouncer, edge, toggle and hold detection
module input_conditioner #(
  parameter int CHANNELS      = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] held,
  output logic                any_rise
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          clean_q, clean_d;
    logic          rise_q, fall_q, toggle_q;
    logic          accept;
    logic [SW-1:0] stab_q, stab_d;
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
      accept = 1'b0;
      stab_d = '0;
      if (sync2_q != clean_q) begin
        if (stab_q == STABLE_LAST) begin
          accept = 1'b1;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      clean_d = accept ? sync2_q : clean_q;

      // Keyed on the next clean value so held drops on the same edge as fall.
      hold_d = '0;
      if (clean_d) begin
        hold_d = (clean_q && (hold_q != HOLD_MAX)) ? hold_q + HW'(1) : hold_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        clean_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
        stab_q   <= '0;
        hold_q   <= '0;
      end else begin
        sync1_q  <= noisy[g];
        sync2_q  <= sync1_q;
        clean_q  <= clean_d;
        rise_q   <= accept & sync2_q;
        fall_q   <= accept & ~sync2_q;
        toggle_q <= toggle_q ^ (accept & sync2_q);
        stab_q   <= stab_d;
        hold_q   <= hold_d;
      end
    end

    assign clean[g]  = clean_q;
    assign rise[g]   = rise_q;
    assign fall[g]   = fall_q;
    assign toggle[g] = toggle_q;
    assign held[g]   = (hold_q == HOLD_MAX);
  end

  assign any_rise = |rise;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

  localparam int C = 4;
  localparam int S = 4;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [C-1:0] noisy = '0;
  logic [C-1:0] clean, rise, fall, toggle, held;
  logic         any_rise;

  int n_tests = 0;
  int n_fail  = 0;
  int rise3_cnt = 0;
  int fall3_cnt = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .CHANNELS(C),
    .STABLE_CYCLES(S),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .noisy(noisy),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .toggle(toggle),
    .held(held),
    .any_rise(any_rise)
  );

  task automatic check(input string name, input logic [C-1:0] act, input logic [C-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clean flips once the last S synchronized samples all disagree with it.
  logic [C-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_toggle;
  logic [S-1:0] m_hist [C];
  int           m_since [C];

  initial begin
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_toggle = '0;
    for (int c = 0; c < C; c++) begin
      m_hist[c] = '0;
      m_since[c] = 0;
    end
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_toggle = '0;
        for (int c = 0; c < C; c++) begin
          m_hist[c] = '0;
          m_since[c] = 0;
        end
      end else begin
        for (int c = 0; c < C; c++) begin
          m_hist[c] = {m_hist[c][S-2:0], m_s2[c]};
          m_rise[c] = 1'b0;
          m_fall[c] = 1'b0;
          if (m_hist[c] == {S{~m_clean[c]}}) begin
            m_clean[c] = ~m_clean[c];
            m_rise[c]  = m_clean[c];
            m_fall[c]  = ~m_clean[c];
            if (m_clean[c]) m_toggle[c] = ~m_toggle[c];
            m_since[c] = 0;
          end else if (m_clean[c] && m_since[c] < H) begin
            m_since[c]++;
          end
        end
        m_s2 = m_s1;
        m_s1 = noisy;
      end
    end
  end

  initial begin
    logic [C-1:0] held_exp;
    forever begin
      @(negedge clk);
      for (int c = 0; c < C; c++) held_exp[c] = m_clean[c] && (m_since[c] >= H);
      check("m_clean", clean, m_clean);
      check("m_rise", rise, m_rise);
      check("m_fall", fall, m_fall);
      check("m_toggle", toggle, m_toggle);
      check("m_held", held, held_exp);
      check("m_any_rise", C'(any_rise), C'(|m_rise));
      if (rise[3]) rise3_cnt++;
      if (fall[3]) fall3_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(3);
    check("rst_clean", clean, 4'b0000);
    check("rst_toggle", toggle, 4'b0000);
    check("rst_held", held, 4'b0000);
    reset_n = 1'b1;
    step(2);

    noisy = 4'b0001;
    step(5);
    check("ch0_pre", clean, 4'b0000);
    step(1);
    check("ch0_clean", clean, 4'b0001);
    check("ch0_rise", rise, 4'b0001);
    check("ch0_any", C'(any_rise), 4'b0001);
    check("ch0_toggle", toggle, 4'b0001);
    step(1);
    check("ch0_rise_end", rise, 4'b0000);
    noisy = 4'b0000;
    step(6);
    check("ch0_fall", fall, 4'b0001);
    check("ch0_toggle_kept", toggle, 4'b0001);
    step(2);

    noisy = 4'b0010;
    step(3);
    noisy = 4'b0000;
    step(10);
    check("ch1_glitch_clean", clean, 4'b0000);
    check("ch1_glitch_toggle", toggle, 4'b0001);

    noisy = 4'b0100;
    step(6);
    check("ch2_clean", clean, 4'b0100);
    check("ch2_rise", rise, 4'b0100);
    step(7);
    check("ch2_held_pre", held, 4'b0000);
    step(1);
    check("ch2_held", held, 4'b0100);
    step(6);
    noisy = 4'b0000;
    step(5);
    check("ch2_held_still", held, 4'b0100);
    step(1);
    check("ch2_drop_clean", clean, 4'b0000);
    check("ch2_drop_held", held, 4'b0000);
    check("ch2_drop_fall", fall, 4'b0100);
    step(2);

    rise3_cnt = 0;
    fall3_cnt = 0;
    check("ch3_tog0", C'(toggle[3]), 4'b0000);
    noisy = 4'b1000; step(8);
    check("ch3_tog1", C'(toggle[3]), 4'b0001);
    noisy = 4'b0000; step(8);
    check("ch3_tog2", C'(toggle[3]), 4'b0001);
    noisy = 4'b1000; step(8);
    check("ch3_tog3", C'(toggle[3]), 4'b0000);
    noisy = 4'b0000; step(8);
    check("ch3_tog4", C'(toggle[3]), 4'b0000);
    check("ch3_rises", C'(rise3_cnt), 4'd2);
    check("ch3_falls", C'(fall3_cnt), 4'd2);

    noisy = 4'b1111;
    step(5);
    check("all_pre", rise, 4'b0000);
    step(1);
    check("all_rise", rise, 4'b1111);
    check("all_any", C'(any_rise), 4'b0001);
    check("all_toggle", toggle, 4'b1010);
    step(4);
    reset_n = 1'b0;
    #1;
    check("arst_clean", clean, 4'b0000);
    check("arst_rise", rise, 4'b0000);
    check("arst_fall", fall, 4'b0000);
    check("arst_toggle", toggle, 4'b0000);
    check("arst_held", held, 4'b0000);
    check("arst_any", C'(any_rise), 4'b0000);
    step(2);
    reset_n = 1'b1;
    step(5);
    check("rel_pre_rise", rise, 4'b0000);
    check("rel_pre_clean", clean, 4'b0000);
    step(1);
    check("rel_rise", rise, 4'b1111);
    check("rel_clean", clean, 4'b1111);
    check("rel_toggle", toggle, 4'b1111);
    step(7);
    check("rel_held_pre", held, 4'b0000);
    step(1);
    check("rel_held", held, 4'b1111);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: CHANNELS, 8, number of independent input channels (1..32).
REQ-002 Parameter: STABLE_CYCLES, 1000000, cycles a synchronized level must persist before acceptance (>=2; 10 ms at 100 MHz).
REQ-003 Parameter: HOLD_CYCLES, 50000000, cycles clean must stay high before held asserts (>=1).
REQ-004 Port: clk  input  1  single system clock; all state on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: noisy  input  CHANNELS  raw asynchronous switch/button levels.
REQ-007 Port: clean  output  CHANNELS  debounced level per channel.
REQ-008 Port: rise  output  CHANNELS  one-cycle pulse when clean goes 0->1.
REQ-009 Port: fall  output  CHANNELS  one-cycle pulse when clean goes 1->0.
REQ-010 Port: toggle  output  CHANNELS  level that inverts on each rise (latching pause-style control).
REQ-011 Port: held  output  CHANNELS  high while clean has been high >= HOLD_CYCLES.
REQ-012 Port: any_rise  output  1  OR-reduction of rise.

Function
REQ-013 Each channel SHALL pass noisy through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-014 Each channel SHALL own a stability counter of width clog2(STABLE_CYCLES); no counter is shared between channels.
REQ-015 Counter rule per edge: sync2==clean -> counter cleared to 0; sync2!=clean and counter<STABLE_CYCLES-1 -> counter+1; sync2!=clean and counter==STABLE_CYCLES-1 -> clean<=sync2, counter<=0.
REQ-016 Latency: with noisy held steady after a change, clean SHALL take the new value exactly STABLE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-017 A glitch that returns sync2 to the clean value before acceptance SHALL restart the count; clean, rise, fall SHALL not change.
REQ-018 rise/fall SHALL be registered and asserted for exactly one cycle, the first cycle clean shows the new value; never both high on one channel.
REQ-019 toggle SHALL invert on the same edge that sets rise; fall SHALL not affect toggle.
REQ-020 Hold counter per channel: cleared while clean==0; increments while clean==1; saturates at HOLD_CYCLES; held==1 iff counter==HOLD_CYCLES.
REQ-021 held SHALL deassert on the same edge clean falls (same cycle fall is high).
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 any_rise SHALL be combinational OR of the registered rise vector (no extra latency).
REQ-024 Counters SHALL never wrap; widths SHALL be derived from parameters.

Reset
REQ-025 reset_n low SHALL asynchronously force sync1, sync2, clean, rise, fall, toggle, held, any_rise and all counters to 0.
REQ-026 Release of reset_n SHALL take effect on the next rising edge; a channel whose noisy is high at release SHALL produce rise after STABLE_CYCLES+2 edges, as for any 0->1 change.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard partial counts; no pulse SHALL be emitted on or after the reset edge until a fresh full debounce completes.

Verification (bench: CHANNELS=4, STABLE_CYCLES=4, HOLD_CYCLES=8)
REQ-028 noisy[0] 0->1 held steady -> clean[0]=1 at edge 6 after first sampling edge; rise[0] and any_rise high exactly that one cycle; toggle[0]=1.
REQ-029 noisy[1] high for 3 cycles then low -> clean[1], rise[1], fall[1], toggle[1] stay 0 throughout.
REQ-030 noisy[2] high 20 cycles -> held[2] asserts 8 cycles after clean[2] rises; noisy[2] low -> held[2] and clean[2] drop with fall[2] on the same edge.
REQ-031 Two full press/release cycles on noisy[3] -> toggle[3] sequence 0->1->0, changing only on rise edges; exactly two rise and two fall pulses.
REQ-032 noisy=4'b1111 simultaneously -> rise=4'b1111 in one cycle; then reset_n low mid-hold -> all outputs 0 immediately; release with noisy still 1111 -> rise=4'b1111 again 6 edges later.
